// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the data-memory controller.
package dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StResp
    } state_e;

    localparam int unsigned DefaultDataWidth = 32;
    localparam int unsigned NumLanes         = DefaultDataWidth / 8;
    localparam logic [NumLanes-1:0] FullBe   = '1;

endpackage

// File: rtl/dmem_ctrl_be_merge.sv
// Byte-lane merge: lanes with be set take the new word, others keep the old word.
module be_merge #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   old_word,
    input  logic [DATA_WIDTH-1:0]   new_word,
    input  logic [DATA_WIDTH/8-1:0] be,
    output logic [DATA_WIDTH-1:0]   merged
);

    always_comb begin
        merged = old_word;
        for (int unsigned i = 0; i < DATA_WIDTH / 8; i++) begin
            if (be[i]) begin
                merged[i*8 +: 8] = new_word[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Single-outstanding data-memory controller in front of a combinational-read SRAM.
// Partial stores are done as read-modify-write; all outputs are registered.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = DefaultDataWidth
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH+1:0]   req_addr,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    input  logic [DATA_WIDTH-1:0]   req_wdata,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,

    output logic                    mem_rd_en,
    output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]   mem_rd_data,
    output logic                    mem_wr_en,
    output logic [ADDR_WIDTH-1:0]   mem_wr_addr,
    output logic [DATA_WIDTH-1:0]   mem_wr_data
);

    localparam int unsigned Lanes = DATA_WIDTH / 8;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   word_addr_q;
    logic                    we_q;
    logic [Lanes-1:0]        be_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   merged_word;

    logic req_fire;
    logic req_bad;
    logic req_full;

    assign req_fire = req_valid && req_ready;
    assign req_bad  = (req_addr[1:0] != 2'b00) || (req_we && (req_be == '0));
    assign req_full = &req_be;

    // Old word comes straight from the SRAM during READ; registered into mem_wr_data.
    be_merge #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_be_merge (
        .old_word (mem_rd_data),
        .new_word (wdata_q),
        .be       (be_q),
        .merged   (merged_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            word_addr_q <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
        end else begin
            // SRAM strobes last one cycle and their address/data return to zero.
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;

            unique case (state_q)
                StIdle: begin
                    if (req_fire) begin
                        word_addr_q <= req_addr[ADDR_WIDTH+1:2];
                        we_q        <= req_we;
                        be_q        <= req_be;
                        wdata_q     <= req_wdata;
                        req_ready   <= 1'b0;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b0;
                        if (req_bad) begin
                            state_q   <= StResp;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else if (req_we && req_full) begin
                            state_q     <= StWrite;
                            mem_wr_en   <= 1'b1;
                            mem_wr_addr <= req_addr[ADDR_WIDTH+1:2];
                            mem_wr_data <= req_wdata;
                        end else begin
                            state_q     <= StRead;
                            mem_rd_en   <= 1'b1;
                            mem_rd_addr <= req_addr[ADDR_WIDTH+1:2];
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end

                StRead: begin
                    if (we_q) begin
                        state_q     <= StWrite;
                        mem_wr_en   <= 1'b1;
                        mem_wr_addr <= word_addr_q;
                        mem_wr_data <= merged_word;
                    end else begin
                        state_q   <= StResp;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= mem_rd_data;
                    end
                end

                StWrite: begin
                    state_q   <= StResp;
                    rsp_valid <= 1'b1;
                end

                StResp: begin
                    if (rsp_ready) begin
                        state_q   <= StIdle;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed table, reset abort, then random traffic.
module tb_dmem_ctrl;
    import dmem_ctrl_pkg::*;

    localparam int unsigned AW    = 11;
    localparam int unsigned DW    = 32;
    localparam int unsigned Words = 1 << AW;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [AW+1:0]     req_addr;
    logic [NumLanes-1:0] req_be;
    logic [DW-1:0]     req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic              mem_rd_en;
    logic [AW-1:0]     mem_rd_addr;
    logic [DW-1:0]     mem_rd_data;
    logic              mem_wr_en;
    logic [AW-1:0]     mem_wr_addr;
    logic [DW-1:0]     mem_wr_data;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_be      (req_be),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data)
    );

    // Deterministic power-up contents; word 4 holds the load test pattern.
    function automatic logic [31:0] init_word(input int w);
        logic [31:0] h;
        h = 32'(w) * 32'h9E37_79B9;
        return (w == 4) ? 32'hDEAD_BEEF : (h ^ 32'h5A5A_0000);
    endfunction

    // SRAM model with write/read activity counters.
    logic [DW-1:0] mem [Words];
    bit            mem_vld [Words];
    int            rd_cnt = 0;
    int            wr_cnt = 0;
    logic [AW-1:0] last_wr_addr;
    logic [DW-1:0] last_wr_data;

    assign mem_rd_data = mem_vld[mem_rd_addr] ? mem[mem_rd_addr] : init_word(int'(mem_rd_addr));

    always @(posedge clk) begin
        if (mem_rd_en) rd_cnt <= rd_cnt + 1;
        if (mem_wr_en) begin
            wr_cnt             <= wr_cnt + 1;
            mem[mem_wr_addr]     <= mem_wr_data;
            mem_vld[mem_wr_addr] <= 1'b1;
            last_wr_addr       <= mem_wr_addr;
            last_wr_data       <= mem_wr_data;
        end
    end

    // Reference memory image, updated from the architectural rules only.
    logic [DW-1:0] ref_mem [Words];

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and check that idle SRAM buses read zero.
    task automatic tick();
        @(negedge clk);
        if (!mem_rd_en) check("rd_addr_zero", 32'(mem_rd_addr), 32'h0);
        if (!mem_wr_en) begin
            check("wr_addr_zero", 32'(mem_wr_addr), 32'h0);
            check("wr_data_zero", mem_wr_data, 32'h0);
        end
    endtask

    task automatic run_txn(input logic we, input logic [12:0] addr, input logic [3:0] be,
                           input logic [31:0] wdata, input int hold, input logic exp_err,
                           input logic [31:0] exp_rdata, input int exp_lat,
                           input logic [31:0] exp_wdat);
        int waitc;
        int lat;
        int rd0;
        int wr0;
        waitc = 0;
        while (!req_ready && waitc < 10) begin
            tick();
            waitc++;
        end
        check("req_ready_idle", 32'(req_ready), 32'h1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_be    = be;
        req_wdata = wdata;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        tick();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_be    = '0;
        req_wdata = '0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            check("req_ready_busy", 32'(req_ready), 32'h0);
            tick();
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rd_pulses", 32'(rd_cnt - rd0), 32'(!exp_err && (!we || be != FullBe)));
        check("wr_pulses", 32'(wr_cnt - wr0), 32'(!exp_err && we));
        if (!exp_err && we) begin
            check("wr_addr", 32'(last_wr_addr), 32'(addr[12:2]));
            check("wr_data", last_wr_data, exp_wdat);
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", 32'(rsp_valid), 32'h1);
            check("hold_rdata", rsp_rdata, exp_rdata);
            check("hold_err", 32'(rsp_err), 32'(exp_err));
            check("hold_req_ready", 32'(req_ready), 32'h0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_valid_drop", 32'(rsp_valid), 32'h0);
        check("req_ready_after", 32'(req_ready), 32'h1);
    endtask

    task automatic model_commit(input logic we, input logic [12:0] addr, input logic [3:0] be,
                                input logic [31:0] wdata);
        int w;
        w = int'(addr[12:2]);
        if (we && addr[1:0] == 2'b00 && be != 4'h0) ref_mem[w] = lane_merge(ref_mem[w], wdata, be);
    endtask

    task automatic model_txn(input logic we, input logic [12:0] addr, input logic [3:0] be,
                             input logic [31:0] wdata, input int hold);
        logic        err;
        int          w;
        int          lat;
        logic [31:0] rdata;
        w     = int'(addr[12:2]);
        err   = (addr[1:0] != 2'b00) || (we && be == 4'h0);
        lat   = err ? 1 : (!we ? 2 : (be == 4'hF ? 2 : 3));
        rdata = (!err && !we) ? ref_mem[w] : 32'h0;
        run_txn(we, addr, be, wdata, hold, err, rdata, lat, lane_merge(ref_mem[w], wdata, be));
        model_commit(we, addr, be, wdata);
    endtask

    typedef struct {
        logic        we;
        logic [12:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          hold;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        logic [31:0] wdat;
    } vec_t;

    vec_t tbl[$];

    initial begin
        for (int i = 0; i < int'(Words); i++) ref_mem[i] = init_word(i);

        tbl.push_back('{1'b0, 13'h010, 4'h0, 32'h0,         0, 1'b0, 32'hDEAD_BEEF, 2, 32'h0});
        tbl.push_back('{1'b1, 13'h020, 4'hF, 32'h1234_5678, 0, 1'b0, 32'h0,         2, 32'h1234_5678});
        tbl.push_back('{1'b1, 13'h020, 4'h2, 32'h0000_AB00, 0, 1'b0, 32'h0,         3, 32'h1234_AB78});
        tbl.push_back('{1'b0, 13'h020, 4'h0, 32'h0,         5, 1'b0, 32'h1234_AB78, 2, 32'h0});
        tbl.push_back('{1'b0, 13'h013, 4'h0, 32'h0,         0, 1'b1, 32'h0,         1, 32'h0});
        tbl.push_back('{1'b1, 13'h024, 4'h0, 32'hFFFF_FFFF, 0, 1'b1, 32'h0,         1, 32'h0});
        tbl.push_back('{1'b1, 13'h023, 4'hF, 32'hFFFF_FFFF, 2, 1'b1, 32'h0,         1, 32'h0});
        tbl.push_back('{1'b1, 13'h028, 4'hF, 32'h1122_3344, 0, 1'b0, 32'h0,         2, 32'h1122_3344});
        tbl.push_back('{1'b1, 13'h028, 4'h9, 32'hAABB_CCDD, 1, 1'b0, 32'h0,         3, 32'hAA22_33DD});
        tbl.push_back('{1'b0, 13'h028, 4'h0, 32'h0,         0, 1'b0, 32'hAA22_33DD, 2, 32'h0});
        tbl.push_back('{1'b1, 13'h1FFC, 4'hF, 32'hCAFE_F00D, 0, 1'b0, 32'h0,        2, 32'hCAFE_F00D});
        tbl.push_back('{1'b0, 13'h1FFC, 4'h0, 32'h0,        0, 1'b0, 32'hCAFE_F00D, 2, 32'h0});

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_be    = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;

        repeat (3) tick();
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", 32'(rsp_err), 32'h0);
        check("rst_rd_en", 32'(mem_rd_en), 32'h0);
        check("rst_wr_en", 32'(mem_wr_en), 32'h0);
        rst_n = 1'b1;
        tick();
        check("req_ready_post_rst", 32'(req_ready), 32'h1);

        foreach (tbl[i]) begin
            run_txn(tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].wdata, tbl[i].hold,
                    tbl[i].err, tbl[i].rdata, tbl[i].lat, tbl[i].wdat);
            model_commit(tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].wdata);
        end

        // Reset during the READ phase of a partial store must not write the SRAM.
        begin
            int wr0;
            wr0 = wr_cnt;
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = 13'h028;
            req_be    = 4'h1;
            req_wdata = 32'h0000_0077;
            tick();
            req_valid = 1'b0;
            req_we    = 1'b0;
            req_addr  = '0;
            req_be    = '0;
            req_wdata = '0;
            check("abort_in_read", 32'(mem_rd_en), 32'h1);
            rst_n = 1'b0;
            #1;
            check("abort_rd_en", 32'(mem_rd_en), 32'h0);
            check("abort_wr_en", 32'(mem_wr_en), 32'h0);
            check("abort_req_ready", 32'(req_ready), 32'h0);
            check("abort_rsp_valid", 32'(rsp_valid), 32'h0);
            check("abort_rsp_err", 32'(rsp_err), 32'h0);
            check("abort_rsp_rdata", rsp_rdata, 32'h0);
            repeat (3) tick();
            check("abort_no_write", 32'(wr_cnt - wr0), 32'h0);
            check("abort_rsp_valid_hold", 32'(rsp_valid), 32'h0);
            rst_n = 1'b1;
            tick();
            check("abort_ready_release", 32'(req_ready), 32'h1);
            check("abort_no_rsp", 32'(rsp_valid), 32'h0);
            check("abort_no_write_late", 32'(wr_cnt - wr0), 32'h0);
        end
        model_txn(1'b0, 13'h028, 4'h0, 32'h0, 0);

        for (int n = 0; n < 200; n++) begin
            logic        we;
            logic [12:0] addr;
            logic [3:0]  be;
            int          sel;
            we   = 1'($urandom_range(0, 1));
            addr = {11'($urandom_range(0, 31)), 2'b00};
            if ($urandom_range(0, 15) == 0) addr[12:2] = 11'($urandom_range(2016, 2047));
            if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            sel = int'($urandom_range(0, 7));
            be  = (sel < 3) ? 4'hF : (sel == 3) ? 4'h0 : 4'($urandom);
            model_txn(we, addr, be, $urandom, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 11, giving the SRAM word-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the word width; byte lanes = DATA_WIDTH/8.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-004 The block SHALL have the following ports, one per line (name  direction  width  meaning):
  req_valid  in  1  request present
  req_ready  out  1  request accepted when high with req_valid
  req_we  in  1  1 = store, 0 = load
  req_addr  in  ADDR_WIDTH+2  byte address
  req_be  in  DATA_WIDTH/8  store byte enables
  req_wdata  in  DATA_WIDTH  store data
  rsp_valid  out  1  response present
  rsp_ready  in  1  response consumed when high with rsp_valid
  rsp_rdata  out  DATA_WIDTH  load data (0 for stores and errors)
  rsp_err  out  1  request rejected
  mem_rd_en  out  1  SRAM read enable
  mem_rd_addr  out  ADDR_WIDTH  SRAM read word address
  mem_rd_data  in  DATA_WIDTH  SRAM combinational read data
  mem_wr_en  out  1  SRAM write enable
  mem_wr_addr  out  ADDR_WIDTH  SRAM write word address
  mem_wr_data  out  DATA_WIDTH  SRAM write data

Function
REQ-005 The FSM SHALL have states IDLE, READ, WRITE, RESP.
REQ-006 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted (addr, we, be, wdata latched) in the cycle req_valid && req_ready.
REQ-007 An accepted request with req_addr[1:0] != 0, or a store with req_be == 0, SHALL go IDLE -> RESP with rsp_err=1, rsp_rdata=0, and no SRAM access.
REQ-008 Load: IDLE -> READ -> RESP; in READ, mem_rd_en=1, mem_rd_addr=latched addr[ADDR_WIDTH+1:2]; mem_rd_data SHALL be registered into rsp_rdata at the end of READ.
REQ-009 Full store (all req_be bits set): IDLE -> WRITE -> RESP; mem_wr_data = latched wdata.
REQ-010 Partial store: IDLE -> READ -> WRITE -> RESP; in WRITE, each byte lane SHALL take wdata where be=1, else the old word captured in READ.
REQ-011 mem_wr_en SHALL be 1 only in WRITE, for exactly one cycle per successful store; mem_rd_en SHALL be 1 only in READ.
REQ-012 Latency from accept cycle N: load rsp_valid at N+2; full store N+2; partial store N+3; error N+1.
REQ-013 In RESP, rsp_valid=1 and rsp_rdata/rsp_err SHALL be held stable until rsp_ready=1; then RESP -> IDLE the next cycle, rsp_valid=0.
REQ-014 Back-to-back requests SHALL be accepted no earlier than the cycle after response handshake (one request outstanding maximum).
REQ-015 mem_rd_addr, mem_wr_addr, mem_wr_data SHALL be 0 when their enable is low.
REQ-016 Address arithmetic SHALL discard req_addr[1:0]; no wrap or bounds check beyond ADDR_WIDTH truncation.

Reset
REQ-017 On rst_n=0, asynchronously: state=IDLE, req_ready=0 during reset then 1 after release, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_rd_en=0, mem_wr_en=0, all latched request fields=0.
REQ-018 Reset asserted mid-operation SHALL abort the request; no SRAM write SHALL occur from the aborted request and no response SHALL be issued.

Structure
REQ-019 A shared package dmem_ctrl_pkg SHALL hold the state enum, lane count, and full-byte-enable constant.
REQ-020 Byte-lane merging SHALL be a sub-module be_merge (old word, new word, be -> merged word), purely combinational.
REQ-021 The SRAM itself SHALL stay outside this block.

Verification
REQ-022 Load addr 0x010 with SRAM word 4 = 0xDEADBEEF -> rsp_valid at N+2, rsp_rdata=0xDEADBEEF, rsp_err=0, no mem_wr_en.
REQ-023 Store addr 0x020, be=4'hF, wdata=0x12345678 -> one mem_wr_en at N+1, wr_addr=8, wr_data=0x12345678; rsp at N+2, rdata=0.
REQ-024 Word 8=0x12345678, store be=4'b0010, wdata=0x0000AB00 -> READ at N+1, write 0x1234AB78 at N+2, rsp at N+3.
REQ-025 Load addr 0x013 -> rsp_err=1 at N+1, no mem_rd_en/mem_wr_en.
REQ-026 Hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0; release -> req_ready=1 next cycle.
REQ-027 Assert rst_n=0 during READ of a partial store -> no mem_wr_en, all outputs at reset values.
